pwm_duty_capture: RTL

//   Receive-side counterpart of the PWM generator: samples an incoming PWM line and

---
 rtl/pwm_duty_capture.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pwm_duty_capture.sv
// Recovers the duty word of an incoming PWM line by counting high samples per frame
// on the same tick grid as the generator; reports malformed frames and stuck-high lines.
module pwm_duty_capture #(
    parameter int WIDTH = 8,
    parameter int DVSR  = 10417
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             locked_o
);

    localparam int FRAME = 1 << WIDTH;
    localparam int TMO   = 2 * FRAME;

    localparam logic [WIDTH+1:0] PER_FRAME  = (WIDTH+2)'(FRAME);
    localparam logic [WIDTH+1:0] PER_TMO_M1 = (WIDTH+2)'(TMO - 1);
    localparam logic [WIDTH+1:0] PER_ONE    = (WIDTH+2)'(1);
    localparam logic [WIDTH:0]   HI_ONE     = (WIDTH+1)'(1);
    localparam logic [31:0]      Q_LAST     = 32'(DVSR);

    typedef enum logic {
        SEEK,
        MEASURE
    } state_t;

    state_t           state, state_nxt;
    logic             sync_meta, s_sync;
    logic             prev, prev_nxt;
    logic [31:0]      q, q_nxt;
    logic [WIDTH+1:0] per_cnt, per_nxt;
    logic [WIDTH:0]   hi_cnt, hi_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic             valid_nxt, err_nxt, locked_nxt;
    logic             tick, rise;

    assign tick = ena && (q == '0);
    assign rise = s_sync & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            s_sync    <= 1'b0;
        end else begin
            sync_meta <= pwm_i;
            s_sync    <= sync_meta;
        end
    end

    always_comb begin
        q_nxt = q;
        if (!ena) begin
            q_nxt = '0;
        end else if (q == Q_LAST) begin
            q_nxt = '0;
        end else begin
            q_nxt = q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEEK;
            prev     <= 1'b0;
            q        <= '0;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            duty_o   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            q        <= q_nxt;
            per_cnt  <= per_nxt;
            hi_cnt   <= hi_nxt;
            duty_o   <= duty_nxt;
            valid_o  <= valid_nxt;
            err_o    <= err_nxt;
            locked_o <= locked_nxt;
        end
    end

    // Every decision is taken on a tick; a rise closes the running frame, and a line
    // that stays quiet for two frames is judged by its level (low = duty 0, high = fault).
    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev;
        per_nxt    = per_cnt;
        hi_nxt     = hi_cnt;
        duty_nxt   = duty_o;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        locked_nxt = locked_o;

        if (!ena) begin
            state_nxt = SEEK;
            prev_nxt  = 1'b0;
            per_nxt   = '0;
            hi_nxt    = '0;
        end else if (tick) begin
            prev_nxt = s_sync;
            if (rise) begin
                if (state == MEASURE) begin
                    if (per_cnt == PER_FRAME) begin
                        duty_nxt   = hi_cnt[WIDTH-1:0];
                        valid_nxt  = 1'b1;
                        locked_nxt = 1'b1;
                    end else begin
                        err_nxt    = 1'b1;
                        locked_nxt = 1'b0;
                    end
                end
                state_nxt = MEASURE;
                per_nxt   = PER_ONE;
                hi_nxt    = HI_ONE;
            end else if (per_cnt == PER_TMO_M1) begin
                if (s_sync) begin
                    err_nxt    = 1'b1;
                    locked_nxt = 1'b0;
                end else begin
                    duty_nxt   = '0;
                    valid_nxt  = 1'b1;
                    locked_nxt = 1'b1;
                end
                state_nxt = SEEK;
                per_nxt   = '0;
                hi_nxt    = '0;
            end else begin
                per_nxt = per_cnt + PER_ONE;
                if (state == MEASURE) begin
                    hi_nxt = hi_cnt + {{WIDTH{1'b0}}, s_sync};
                end
            end
        end
    end

endmodule
